acc_seq_ctrl: RTL and testbench
===============================

// Module: acc_seq_ctrl
// PURPOSE
// Microsequencer for the 8-bit accumulator CPU datapath. Steps a fetch/decode/execute ring
//   (T1..T6) and drives the control lines of PC, MAR, RAM, IR, B register, ALU,
//   accumulator (IA/EA/SE) and output register.
// Sits between the instruction register (opcode input) and the shared 8-bit bus datapath.
// Supports free-run, single-step and halt; optionally skips idle T-states of short instructions.
// PARAMETERS
// OP_W      4  opcode width (upper nibble of IR)
// SKIP_NOP  1  1: return to T1 right after the last active T-state; 0: always walk T1..T6
// CNT_W     8  width of retired-instruction counter
// PORTS
// clk        in   1      rising-edge clock, single domain
// rst        in   1      synchronous, active-high reset
// run        in   1      level; 1 leaves IDLE and keeps sequencing
// step_mode  in   1      1: advance one T-state per step pulse only
// step       in   1      single-cycle pulse; ignored when step_mode=0
// opcode     in   OP_W   IR upper nibble; sampled in T4
// EP         out  1      PC drives bus (active-high)
// CP         out  1      PC increment (active-high)
// LM_n       out  1      MAR load (active-low)
// CE_n       out  1      RAM drives bus (active-low)
// LI_n       out  1      IR load (active-low)
// EI_n       out  1      IR operand drives bus (active-low)
// LB_n       out  1      B register load (active-low)
// SU         out  1      ALU subtract select
// EU         out  1      ALU drives bus
// IA         out  1      accumulator load (active-low)
// EA         out  1      accumulator drives bus
// SE         out  1      accumulator source: 1=bus, 0=ALU
// LO_n       out  1      output register load (active-low)
// halt       out  1      1 while in HALT
// tstate     out  3      current state encoding (IDLE=0, T1..T6=1..6, HALT=7)
// instr_cnt  out  CNT_W  instructions retired, wraps to 0
// BEHAVIOUR
// Reset: state=IDLE, op_q=0, instr_cnt=0, halt=0; all controls inactive
//   (EP=CP=SU=EU=EA=SE=0; LM_n=CE_n=LI_n=EI_n=LB_n=IA=LO_n=1).
// Controls are combinational from {state, opcode (T4) / op_q (T5,T6)}; inactive in IDLE/HALT.
// Advance enable adv = run & (~step_mode | step). No adv -> state holds, controls stay
//   asserted for the held state.
// IDLE -> T1 on adv. T1: EP,LM_n=0. T2: CP. T3: CE_n=0,LI_n=0.
// op_q <= opcode on the adv edge leaving T4.
// LDA 0000: T4 EI_n=0,LM_n=0; T5 CE_n=0,IA=0,SE=1; T6 none.
// ADD 0001: T4 EI_n=0,LM_n=0; T5 CE_n=0,LB_n=0; T6 EU=1,IA=0,SE=0.
// SUB 0010: as ADD, plus SU=1 in T6.
// LDI 0011: T4 EI_n=0,IA=0,SE=1; T5,T6 none.
// OUT 1110: T4 EA=1,LO_n=0; T5,T6 none.
// HLT 1111: T4 no controls; next adv -> HALT. HALT exits only via rst; run/step ignored.
// Any other opcode: NOP (T4..T6 no controls).
// Last active T-state: LDA=T5, ADD/SUB=T6, LDI/OUT=T4, NOP=T3.
//   SKIP_NOP=1: from it go to T1; SKIP_NOP=0: always T6->T1.
// instr_cnt increments on the adv edge that returns to T1; wraps at 2^CNT_W-1 -> 0.
//   HLT is not counted.
// run deasserted mid-instruction: state holds (no jump to IDLE). run only gates adv.
// rst mid-instruction: next edge is IDLE with all controls inactive, regardless of state/step.
// Datapath must never see IA=0 together with EA=1, or two bus drivers in one T-state
//   (EP, CE_n=0, EI_n=0, EU, EA mutually exclusive).
// STRUCTURE
// Shared pkg acc_cpu_pkg: opcode constants (OP_LDA..OP_HLT), state encodings,
//   inactive-control default vector.
// Sub-module acc_ucode_rom: pure combinational {state, op} -> control word plus last_t flag.
//   Top holds state reg, op_q, step gating and counter.
// TESTING
// Reset, run=0 10 cycles -> tstate=0, IA=1, LM_n=1, EA=0 throughout; instr_cnt=0.
// run=1, opcode=0000 (LDA), SKIP_NOP=1 -> tstates 1,2,3,4,5,1; T5: CE_n=0,IA=0,SE=1; instr_cnt=1.
// SUB: T6 IA=0,SE=0,EU=1,SU=1; SKIP_NOP=0 with LDI -> T5,T6 inactive, then T1.
// step_mode=1, step pulse every 4th cycle -> one T-state per pulse; controls held between pulses.
// HLT -> after T4, tstate=7, halt=1, all controls inactive, run/step ignored; rst -> IDLE.
// 256 LDI loops -> instr_cnt wraps to 0; rst asserted in T5 of ADD -> next cycle IDLE, LB_n=1.
// Every cycle: at most one bus driver asserted.

Source files
------------

// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, sequencer states and
// the control word that the microsequencer drives into the datapath.
package acc_cpu_pkg;

  localparam int unsigned OPC_W = 4;
  localparam int unsigned ST_W  = 3;

  localparam logic [OPC_W-1:0] OP_LDA = 4'h0;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h1;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h2;
  localparam logic [OPC_W-1:0] OP_LDI = 4'h3;
  localparam logic [OPC_W-1:0] OP_OUT = 4'hE;
  localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [ST_W-1:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_T5   = 3'd5,
    S_T6   = 3'd6,
    S_HALT = 3'd7
  } state_t;

  // Mixed polarity: *_n and ia are active-low, the rest active-high.
  typedef struct packed {
    logic ep;
    logic cp;
    logic lm_n;
    logic ce_n;
    logic li_n;
    logic ei_n;
    logic lb_n;
    logic su;
    logic eu;
    logic ia;
    logic ea;
    logic se;
    logic lo_n;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    ep: 1'b0, cp: 1'b0, lm_n: 1'b1, ce_n: 1'b1, li_n: 1'b1, ei_n: 1'b1,
    lb_n: 1'b1, su: 1'b0, eu: 1'b0, ia: 1'b1, ea: 1'b0, se: 1'b0, lo_n: 1'b1
  };

endpackage

// File: rtl/acc_ucode_rom.sv
// Combinational microcode: {state, opcode} -> datapath control word, plus a
// flag marking the last T-state that does useful work for this opcode.
module acc_ucode_rom
  import acc_cpu_pkg::*;
#(
  parameter int unsigned OP_W = 4
) (
  input  state_t          state,
  input  logic [OP_W-1:0] op,
  output ctrl_t           ctrl,
  output logic            last_t
);

  logic is_lda, is_add, is_sub, is_ldi, is_out, is_hlt, is_mem;

  assign is_lda = (op == OP_W'(OP_LDA));
  assign is_add = (op == OP_W'(OP_ADD));
  assign is_sub = (op == OP_W'(OP_SUB));
  assign is_ldi = (op == OP_W'(OP_LDI));
  assign is_out = (op == OP_W'(OP_OUT));
  assign is_hlt = (op == OP_W'(OP_HLT));
  assign is_mem = is_lda | is_add | is_sub;

  always_comb begin
    ctrl   = CTRL_IDLE;
    last_t = 1'b0;
    case (state)
      S_T1: begin
        ctrl.ep   = 1'b1;
        ctrl.lm_n = 1'b0;
      end
      S_T2: ctrl.cp = 1'b1;
      S_T3: begin
        ctrl.ce_n = 1'b0;
        ctrl.li_n = 1'b0;
        last_t    = ~(is_mem | is_ldi | is_out | is_hlt);
      end
      S_T4: begin
        if (is_mem) begin
          ctrl.ei_n = 1'b0;
          ctrl.lm_n = 1'b0;
        end else if (is_ldi) begin
          ctrl.ei_n = 1'b0;
          ctrl.ia   = 1'b0;
          ctrl.se   = 1'b1;
        end else if (is_out) begin
          ctrl.ea   = 1'b1;
          ctrl.lo_n = 1'b0;
        end
        last_t = is_ldi | is_out | is_hlt;
      end
      S_T5: begin
        if (is_lda) begin
          ctrl.ce_n = 1'b0;
          ctrl.ia   = 1'b0;
          ctrl.se   = 1'b1;
        end else if (is_add | is_sub) begin
          ctrl.ce_n = 1'b0;
          ctrl.lb_n = 1'b0;
        end
        last_t = is_lda;
      end
      S_T6: begin
        if (is_add | is_sub) begin
          ctrl.eu = 1'b1;
          ctrl.ia = 1'b0;
          ctrl.se = 1'b0;
          ctrl.su = is_sub;
        end
        last_t = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/acc_seq_ctrl.sv
// Microsequencer for the 8-bit accumulator CPU: walks the T1..T6 ring with
// free-run / single-step / halt and counts retired instructions.
module acc_seq_ctrl
  import acc_cpu_pkg::*;
#(
  parameter int unsigned OP_W     = 4,
  parameter bit          SKIP_NOP = 1'b1,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step_mode,
  input  logic             step,
  input  logic [OP_W-1:0]  opcode,
  output logic             EP,
  output logic             CP,
  output logic             LM_n,
  output logic             CE_n,
  output logic             LI_n,
  output logic             EI_n,
  output logic             LB_n,
  output logic             SU,
  output logic             EU,
  output logic             IA,
  output logic             EA,
  output logic             SE,
  output logic             LO_n,
  output logic             halt,
  output logic [2:0]       tstate,
  output logic [CNT_W-1:0] instr_cnt
);

  state_t          state_q, state_d;
  logic [OP_W-1:0] op_q, op_sel;
  logic            adv, last_t, ret_t1;
  ctrl_t           ctrl;

  assign adv = run & (~step_mode | step);

  // IR is live through T4; afterwards the latched copy keeps the instruction stable.
  assign op_sel = ((state_q == S_T5) || (state_q == S_T6)) ? op_q : opcode;

  acc_ucode_rom #(.OP_W(OP_W)) u_rom (
    .state  (state_q),
    .op     (op_sel),
    .ctrl   (ctrl),
    .last_t (last_t)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      instr_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (adv && (state_q == S_T4)) op_q <= opcode;
      if (ret_t1) instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    ret_t1  = 1'b0;
    if (adv) begin
      case (state_q)
        S_IDLE: state_d = S_T1;
        S_HALT: state_d = S_HALT;
        default: begin
          if ((state_q == S_T4) && (op_sel == OP_W'(OP_HLT))) begin
            state_d = S_HALT;
          end else if ((state_q == S_T6) || (SKIP_NOP && last_t)) begin
            state_d = S_T1;
            ret_t1  = 1'b1;
          end else begin
            state_d = state_t'(state_q + ST_W'(1));
          end
        end
      endcase
    end
  end

  assign EP     = ctrl.ep;
  assign CP     = ctrl.cp;
  assign LM_n   = ctrl.lm_n;
  assign CE_n   = ctrl.ce_n;
  assign LI_n   = ctrl.li_n;
  assign EI_n   = ctrl.ei_n;
  assign LB_n   = ctrl.lb_n;
  assign SU     = ctrl.su;
  assign EU     = ctrl.eu;
  assign IA     = ctrl.ia;
  assign EA     = ctrl.ea;
  assign SE     = ctrl.se;
  assign LO_n   = ctrl.lo_n;
  assign halt   = (state_q == S_HALT);
  assign tstate = state_q;

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Bench for acc_seq_ctrl: a cycle model pushes expected {tstate, controls,
// instr_cnt, halt} into a queue; each scenario pops and compares after the edge.
module tb_acc_seq_ctrl;

  localparam int I_EP = 12, I_CP = 11, I_LM = 10, I_CE = 9, I_LI = 8, I_EI = 7;
  localparam int I_LB = 6, I_SU = 5, I_EU = 4, I_IA = 3, I_EA = 2, I_SE = 1, I_LO = 0;
  localparam logic [12:0] INACT = 13'b0_0_1_1_1_1_1_0_0_1_0_0_1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       step_mode = 1'b0;
  logic       step = 1'b0;
  logic [3:0] opcode = 4'h0;

  logic [12:0] c1, c0;
  logic [2:0]  t1, t0;
  logic [7:0]  n1, n0;
  logic        h1, h0;
  logic [24:0] obs1, obs0;

  logic [2:0] m_t = 3'd0;
  logic [3:0] m_opq = 4'h0;
  logic [7:0] m_cnt = 8'd0;
  logic [24:0] sbq[$];

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  acc_seq_ctrl #(.OP_W(4), .SKIP_NOP(1'b1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .run(run), .step_mode(step_mode), .step(step), .opcode(opcode),
    .EP(c1[I_EP]), .CP(c1[I_CP]), .LM_n(c1[I_LM]), .CE_n(c1[I_CE]), .LI_n(c1[I_LI]),
    .EI_n(c1[I_EI]), .LB_n(c1[I_LB]), .SU(c1[I_SU]), .EU(c1[I_EU]), .IA(c1[I_IA]),
    .EA(c1[I_EA]), .SE(c1[I_SE]), .LO_n(c1[I_LO]), .halt(h1), .tstate(t1), .instr_cnt(n1)
  );

  acc_seq_ctrl #(.OP_W(4), .SKIP_NOP(1'b0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .run(run), .step_mode(step_mode), .step(step), .opcode(opcode),
    .EP(c0[I_EP]), .CP(c0[I_CP]), .LM_n(c0[I_LM]), .CE_n(c0[I_CE]), .LI_n(c0[I_LI]),
    .EI_n(c0[I_EI]), .LB_n(c0[I_LB]), .SU(c0[I_SU]), .EU(c0[I_EU]), .IA(c0[I_IA]),
    .EA(c0[I_EA]), .SE(c0[I_SE]), .LO_n(c0[I_LO]), .halt(h0), .tstate(t0), .instr_cnt(n0)
  );

  assign obs1 = {t1, c1, n1, h1};
  assign obs0 = {t0, c0, n0, h0};

  function automatic logic [3:0] m_last(input logic [3:0] op);
    case (op)
      4'h0:             return 4'd5;
      4'h1, 4'h2:       return 4'd6;
      4'h3, 4'hE, 4'hF: return 4'd4;
      default:          return 4'd3;
    endcase
  endfunction

  function automatic logic [12:0] m_ctrl(input logic [2:0] t, input logic [3:0] op);
    logic [12:0] c;
    c = INACT;
    case (t)
      3'd1: begin c[I_EP] = 1'b1; c[I_LM] = 1'b0; end
      3'd2: c[I_CP] = 1'b1;
      3'd3: begin c[I_CE] = 1'b0; c[I_LI] = 1'b0; end
      3'd4: begin
        if (op == 4'h0 || op == 4'h1 || op == 4'h2) begin c[I_EI] = 1'b0; c[I_LM] = 1'b0; end
        else if (op == 4'h3) begin c[I_EI] = 1'b0; c[I_IA] = 1'b0; c[I_SE] = 1'b1; end
        else if (op == 4'hE) begin c[I_EA] = 1'b1; c[I_LO] = 1'b0; end
      end
      3'd5: begin
        if (op == 4'h0) begin c[I_CE] = 1'b0; c[I_IA] = 1'b0; c[I_SE] = 1'b1; end
        else if (op == 4'h1 || op == 4'h2) begin c[I_CE] = 1'b0; c[I_LB] = 1'b0; end
      end
      3'd6: begin
        if (op == 4'h1 || op == 4'h2) begin
          c[I_EU] = 1'b1; c[I_IA] = 1'b0; c[I_SE] = 1'b0; c[I_SU] = (op == 4'h2);
        end
      end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic [24:0] m_exp();
    logic [3:0] op;
    op = (m_t == 3'd5 || m_t == 3'd6) ? m_opq : opcode;
    return {m_t, m_ctrl(m_t, op), m_cnt, (m_t == 3'd7)};
  endfunction

  // Advance the reference model by one clock using the inputs about to be sampled.
  task automatic m_step(input bit skip);
    logic [3:0] op;
    if (rst) begin
      m_t = 3'd0; m_opq = 4'h0; m_cnt = 8'd0;
    end else if (run && (!step_mode || step)) begin
      if (m_t == 3'd0) m_t = 3'd1;
      else if (m_t != 3'd7) begin
        op = (m_t >= 3'd5) ? m_opq : opcode;
        if (m_t == 3'd4) m_opq = opcode;
        if (m_t == 3'd4 && opcode == 4'hF) m_t = 3'd7;
        else if (m_t == 3'd6 || (skip && {1'b0, m_t} == m_last(op))) begin
          m_t = 3'd1; m_cnt = m_cnt + 8'd1;
        end else m_t = m_t + 3'd1;
      end
    end
  endtask

  task automatic tick(input bit skip, input bit push);
    m_step(skip);
    if (push) sbq.push_back(m_exp());
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; step_mode = 1'b0; step = 1'b0;
    tick(1'b1, 1'b0);
    rst = 1'b0;
  endtask

  // Bus contention / accumulator conflict watch on both instances.
  function automatic int drivers(input logic [12:0] c);
    return int'(c[I_EP]) + int'(!c[I_CE]) + int'(!c[I_EI]) + int'(c[I_EU]) + int'(c[I_EA]);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (drivers(c1) > 1 || drivers(c0) > 1 || (!c1[I_IA] && c1[I_EA]) || (!c0[I_IA] && c0[I_EA]))
        $display("FAIL bus_exclusive t=%0t got c1=%b c0=%b need <=1 driver and no IA/EA clash", $time, c1, c0);
      else passed++;
    end
  end

  task automatic test_reset();
    logic [24:0] e, o;
    rst = 1'b1; run = 1'b0; step_mode = 1'b0; step = 1'b0;
    tick(1'b1, 1'b1);
    e = sbq.pop_front(); o = obs1; checks++;
    if (o !== e) $display("FAIL reset_state got=%h exp=%h", o, e); else passed++;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b1);
      e = sbq.pop_front(); o = obs1; checks++;
      if (o !== e) $display("FAIL reset_idle_%0d got=%h exp=%h", i, o, e); else passed++;
      checks++;
      if (o !== {3'd0, INACT, 8'd0, 1'b0}) $display("FAIL idle_literal_%0d got=%h exp=%h", i, o, {3'd0, INACT, 8'd0, 1'b0});
      else passed++;
    end
  endtask

  task automatic test_lda();
    logic [24:0] e, o;
    int seq[6] = '{1, 2, 3, 4, 5, 1};
    do_reset();
    opcode = 4'h0; run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b1);
      e = sbq.pop_front(); o = obs1; checks++;
      if (o !== e) $display("FAIL lda_cyc%0d got=%h exp=%h", i, o, e); else passed++;
      checks++;
      if (t1 !== 3'(seq[i])) $display("FAIL lda_tstate%0d got=%0d exp=%0d", i, t1, seq[i]); else passed++;
      if (i == 4) begin
        checks++;
        if ({c1[I_CE], c1[I_IA], c1[I_SE]} !== 3'b001)
          $display("FAIL lda_t5_ctrl got=%b exp=001", {c1[I_CE], c1[I_IA], c1[I_SE]});
        else passed++;
      end
    end
    checks++;
    if (n1 !== 8'd1) $display("FAIL lda_instr_cnt got=%0d exp=1", n1); else passed++;
  endtask

  task automatic test_sub();
    logic [24:0] e, o;
    do_reset();
    opcode = 4'h2; run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (m_t == 3'd5) opcode = 4'h0;  // IR changes after T4; op_q must keep SUB
      tick(1'b1, 1'b1);
      e = sbq.pop_front(); o = obs1; checks++;
      if (o !== e) $display("FAIL sub_cyc%0d got=%h exp=%h", i, o, e); else passed++;
      if (i == 5) begin
        checks++;
        if ({t1, c1[I_IA], c1[I_SE], c1[I_EU], c1[I_SU]} !== {3'd6, 4'b0011})
          $display("FAIL sub_t6_ctrl got=%b exp=%b", {t1, c1[I_IA], c1[I_SE], c1[I_EU], c1[I_SU]}, {3'd6, 4'b0011});
        else passed++;
      end
    end
  endtask

  task automatic test_ldi_noskip();
    logic [24:0] e, o;
    do_reset();
    opcode = 4'h3; run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, 1'b1);
      e = sbq.pop_front(); o = obs0; checks++;
      if (o !== e) $display("FAIL ldi_noskip_cyc%0d got=%h exp=%h", i, o, e); else passed++;
      if (i == 4 || i == 5) begin
        checks++;
        if (c0 !== INACT) $display("FAIL ldi_noskip_idle_t%0d got=%b exp=%b", i + 1, c0, INACT); else passed++;
      end
    end
    checks++;
    if ({t0, n0} !== {3'd1, 8'd1}) $display("FAIL ldi_noskip_end got=%0d/%0d exp=1/1", t0, n0); else passed++;
  endtask

  task automatic test_out_nop();
    logic [24:0] e, o;
    do_reset();
    opcode = 4'hE; run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) opcode = 4'h5;
      tick(1'b1, 1'b1);
      e = sbq.pop_front(); o = obs1; checks++;
      if (o !== e) $display("FAIL out_nop_cyc%0d got=%h exp=%h", i, o, e); else passed++;
      if (i == 3) begin
        checks++;
        if ({c1[I_EA], c1[I_LO]} !== 2'b10) $display("FAIL out_t4_ctrl got=%b exp=10", {c1[I_EA], c1[I_LO]}); else passed++;
      end
    end
    checks++;
    if ({t1, n1} !== {3'd1, 8'd2}) $display("FAIL nop_skip_end got=%0d/%0d exp=1/2", t1, n1); else passed++;
  endtask

  task automatic test_step();
    logic [24:0] e, o;
    do_reset();
    opcode = 4'h1; run = 1'b1; step_mode = 1'b1;
    for (int i = 0; i < 28; i++) begin
      step = (i % 4 == 3);
      tick(1'b1, 1'b1);
      e = sbq.pop_front(); o = obs1; checks++;
      if (o !== e) $display("FAIL step_cyc%0d got=%h exp=%h", i, o, e); else passed++;
    end
    step = 1'b0;
    checks++;
    if ({t1, n1} !== {3'd1, 8'd1}) $display("FAIL step_end got=%0d/%0d exp=1/1", t1, n1); else passed++;
    step_mode = 1'b0;
  endtask

  task automatic test_halt();
    logic [24:0] e, o;
    do_reset();
    opcode = 4'hF; run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i >= 6) begin run = i[0]; step_mode = i[1]; step = 1'b1; end
      tick(1'b1, 1'b1);
      e = sbq.pop_front(); o = obs1; checks++;
      if (o !== e) $display("FAIL halt_cyc%0d got=%h exp=%h", i, o, e); else passed++;
    end
    checks++;
    if ({t1, h1, c1, n1} !== {3'd7, 1'b1, INACT, 8'd0})
      $display("FAIL halt_hold got=%h exp=%h", {t1, h1, c1, n1}, {3'd7, 1'b1, INACT, 8'd0});
    else passed++;
    rst = 1'b1; step = 1'b0;
    tick(1'b1, 1'b1);
    e = sbq.pop_front(); o = obs1; checks++;
    if (o !== e) $display("FAIL halt_reset got=%h exp=%h", o, e); else passed++;
    rst = 1'b0; step_mode = 1'b0;
  endtask

  task automatic test_wrap();
    logic [24:0] e, o;
    do_reset();
    opcode = 4'h3; run = 1'b1;
    for (int i = 0; i < 1 + 4 * 256; i++) begin
      tick(1'b1, 1'b1);
      e = sbq.pop_front(); o = obs1; checks++;
      if (o !== e) $display("FAIL wrap_cyc%0d got=%h exp=%h", i, o, e); else passed++;
      if (i == 4 * 255) begin
        checks++;
        if (n1 !== 8'd255) $display("FAIL wrap_255 got=%0d exp=255", n1); else passed++;
      end
    end
    checks++;
    if ({t1, n1} !== {3'd1, 8'd0}) $display("FAIL wrap_zero got=%0d/%0d exp=1/0", t1, n1); else passed++;
  endtask

  task automatic test_rst_mid();
    logic [24:0] e, o;
    do_reset();
    opcode = 4'h1; run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b1);
      e = sbq.pop_front(); o = obs1; checks++;
      if (o !== e) $display("FAIL rstmid_cyc%0d got=%h exp=%h", i, o, e); else passed++;
    end
    checks++;
    if ({t1, c1[I_LB]} !== {3'd5, 1'b0}) $display("FAIL rstmid_t5 got=%0d/%b exp=5/0", t1, c1[I_LB]); else passed++;
    rst = 1'b1; step_mode = 1'b1;
    tick(1'b1, 1'b1);
    e = sbq.pop_front(); o = obs1; checks++;
    if (o !== e) $display("FAIL rstmid_after got=%h exp=%h", o, e); else passed++;
    checks++;
    if ({t1, c1[I_LB]} !== {3'd0, 1'b1}) $display("FAIL rstmid_idle got=%0d/%b exp=0/1", t1, c1[I_LB]); else passed++;
    rst = 1'b0; step_mode = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lda();
    test_sub();
    test_ldi_noskip();
    test_out_nop();
    test_step();
    test_halt();
    test_wrap();
    test_rst_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
